fta_bridge_arbiter32: RTL and testbench

//  Shares one fta2wb_bridge32 among NREQ FTA requesters. Buffers each requester's one-cycle command
//  and grants the bridge round-robin, one transaction in flight at a time. Routes completions back
//  to the owning port, forwards bridge IRQ messages to IRQ_PORT and fails stuck cycles by timeout.

---
 rtl/fta_bridge_arbiter32.sv | 173 +++++++++++++++++
 tb/tb_fta_bridge_arbiter32.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fta_bridge_arbiter32.sv
// FTA bus types plus a round-robin arbiter that shares one fta2wb_bridge32 among NREQ
// requesters. It keeps one transaction in flight, routes completions, forwards IRQs and times out stuck cycles.
package fta_bus_pkg;
  typedef enum logic [2:0] {OKAY = 3'd0, DECERR = 3'd1, SLVERR = 3'd2, IRQ = 3'd3} fta_err_t;
  typedef enum logic [2:0] {CLASSIC = 3'd0, FIXED = 3'd1, INCR = 3'd2, ERC = 3'd7} fta_cti_t;

  typedef struct packed {
    logic        cyc;
    logic        we;
    fta_cti_t    cti;
    logic [7:0]  tid;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic        ack;
    fta_err_t    err;
    logic [7:0]  tid;
    logic [31:0] adr;
    logic [31:0] dat;
  } fta_cmd_response32_t;
endpackage

module fta_bridge_arbiter32
  import fta_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IRQ_PORT = 0,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  fta_cmd_request32_t  req_i   [NREQ],
  output logic [NREQ-1:0]     stall_o,
  output fta_cmd_response32_t resp_o  [NREQ],
  output fta_cmd_request32_t  br_req_o,
  input  fta_cmd_response32_t br_resp_i,
  input  logic                wb_ack_i,
  output logic                to_o
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              r_state, w_state_nxt;
  fta_cmd_request32_t  r_buf  [NREQ];
  fta_cmd_response32_t r_resp [NREQ];
  fta_cmd_response32_t w_err_resp;
  logic [NREQ-1:0]     r_full;
  logic [GW-1:0]       r_grant, r_last, w_sel;
  logic [GW:0]         w_k;
  logic [7:0]          r_tid;
  logic                r_we;
  fta_cti_t            r_cti;
  logic [9:0]          r_timer;
  logic                w_any, w_irq, w_match, w_rsp_type, w_grant_irq;
  logic                w_done, w_dlv_rsp, w_dlv_err;

  assign stall_o     = r_full;
  assign resp_o      = r_resp;
  assign w_irq       = br_resp_i.ack && (br_resp_i.err == IRQ);
  assign w_match     = br_resp_i.ack && (br_resp_i.err != IRQ) && (br_resp_i.tid == r_tid);
  assign w_rsp_type  = !r_we || (r_cti == ERC);
  assign w_grant_irq = (32'(r_grant) == IRQ_PORT);

  always_comb begin
    w_err_resp     = '0;
    w_err_resp.ack = 1'b1;
    w_err_resp.err = DECERR;
    w_err_resp.tid = r_tid;
  end

  // Scan starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_k   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      w_k = {1'b0, r_last} + (GW+1)'(i);
      if (w_k >= (GW+1)'(NREQ)) w_k = w_k - (GW+1)'(NREQ);
      if (!w_any && r_full[w_k[GW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_k[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    br_req_o    = '0;
    to_o        = 1'b0;
    w_done      = 1'b0;
    w_dlv_rsp   = 1'b0;
    w_dlv_err   = 1'b0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = ISSUE;
      ISSUE: begin
        br_req_o     = r_buf[r_grant];
        br_req_o.cyc = 1'b1;
        w_state_nxt  = WAIT;
      end
      WAIT: begin
        w_done = w_rsp_type ? w_match : wb_ack_i;
        if (w_done) begin
          w_dlv_rsp   = w_rsp_type;
          w_state_nxt = IDLE;
        end else if (r_timer == 10'(TIMEOUT)) begin
          to_o        = 1'b1;
          w_state_nxt = IDLE;
          // An IRQ to the same port owns resp_o this cycle; park the error in RESP.
          if (w_rsp_type) begin
            if (w_irq && w_grant_irq) w_state_nxt = RESP;
            else                      w_dlv_err   = 1'b1;
          end
        end
      end
      RESP: begin
        if (!(w_irq && w_grant_irq)) begin
          w_dlv_err   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= '0;
      r_last  <= GW'(NREQ-1);
      r_grant <= '0;
      r_tid   <= '0;
      r_we    <= 1'b0;
      r_cti   <= CLASSIC;
      r_timer <= '0;
      for (int unsigned n = 0; n < NREQ; n++) begin
        r_buf[n]  <= '0;
        r_resp[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NREQ; n++) begin
        if (req_i[n].cyc && !r_full[n]) begin
          r_buf[n]  <= req_i[n];
          r_full[n] <= 1'b1;
        end
        if ((r_state == ISSUE) && (32'(r_grant) == n)) r_full[n] <= 1'b0;

        r_resp[n] <= '0;
        if (w_irq && (n == IRQ_PORT))                          r_resp[n] <= br_resp_i;
        else if (w_dlv_rsp && (32'(r_grant) == n))             r_resp[n] <= br_resp_i;
        else if (w_dlv_err && (32'(r_grant) == n))             r_resp[n] <= w_err_resp;
      end

      if ((r_state == IDLE) && w_any) r_grant <= w_sel;
      if (r_state == ISSUE) begin
        r_tid   <= r_buf[r_grant].tid;
        r_we    <= r_buf[r_grant].we;
        r_cti   <= r_buf[r_grant].cti;
        r_last  <= r_grant;
        r_timer <= '0;
      end else if (r_state == WAIT) begin
        r_timer <= r_timer + 10'd1;
      end
    end
  end
endmodule

// File: tb/tb_fta_bridge_arbiter32.sv
// Directed bench for fta_bridge_arbiter32: a scoreboard queue of expected port responses
// is filled as stimulus is driven and drained by a negedge response monitor.
module tb_fta_bridge_arbiter32;
  import fta_bus_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  fta_cmd_request32_t  req_i  [4];
  logic [3:0]          stall_o;
  fta_cmd_response32_t resp_o [4];
  fta_cmd_request32_t  br_req_o;
  fta_cmd_response32_t br_resp_i;
  logic                wb_ack_i;
  logic                to_o;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int          port;
    logic [7:0]  tid;
    fta_err_t    err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  fta_bridge_arbiter32 #(.NREQ(4), .IRQ_PORT(0), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .stall_o   (stall_o),
    .resp_o    (resp_o),
    .br_req_o  (br_req_o),
    .br_resp_i (br_resp_i),
    .wb_ack_i  (wb_ack_i),
    .to_o      (to_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_reqs();
    for (int i = 0; i < 4; i++) req_i[i] = '0;
  endtask

  task automatic send(input int p, input logic we, input fta_cti_t cti,
                      input logic [7:0] tid, input logic [31:0] adr);
    req_i[p]     = '0;
    req_i[p].cyc = 1'b1;
    req_i[p].we  = we;
    req_i[p].cti = cti;
    req_i[p].tid = tid;
    req_i[p].sel = 4'hF;
    req_i[p].adr = adr;
    req_i[p].dat = {24'h0, tid};
  endtask

  task automatic expect_rsp(input int p, input logic [7:0] tid, input fta_err_t err,
                            input logic [31:0] dat);
    exp_t e;
    e.port = p;
    e.tid  = tid;
    e.err  = err;
    e.dat  = dat;
    sb.push_back(e);
  endtask

  task automatic respond(input logic [7:0] tid, input fta_err_t err, input logic [31:0] dat);
    br_resp_i     = '0;
    br_resp_i.ack = 1'b1;
    br_resp_i.err = err;
    br_resp_i.tid = tid;
    br_resp_i.dat = dat;
    tick();
    br_resp_i = '0;
  endtask

  task automatic wait_grant(input logic [7:0] etid, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!br_req_o.cyc && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {55'd0, br_req_o.cyc, br_req_o.tid}, {55'd0, 1'b1, etid});
  endtask

  // Response monitor: every delivered response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 4; n++) begin
        if (resp_o[n].ack) begin
          exp_t e;
          if (sb.size() > 0) e = sb.pop_front();
          else begin
            e.port = 99; e.tid = '0; e.err = OKAY; e.dat = '0;
          end
          chk("resp_port_tid_err", {21'd0, 32'(n), resp_o[n].tid, resp_o[n].err},
                                   {21'd0, 32'(e.port), e.tid, e.err});
          chk("resp_dat", {32'd0, resp_o[n].dat}, {32'd0, e.dat});
          for (int m = 0; m < 4; m++)
            if (m != n && !resp_o[m].ack)
              chk("quiet_port", {63'd0, (resp_o[m] !== '0)}, 64'd0);
        end
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    wb_ack_i  = 1'b0;
    br_resp_i = '0;
    clr_reqs();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stall", {60'd0, stall_o}, 64'd0);
    chk("rst_brcyc", {63'd0, br_req_o.cyc}, 64'd0);
    chk("rst_to", {63'd0, to_o}, 64'd0);
    for (int p = 0; p < 4; p++) chk("rst_resp", {63'd0, (resp_o[p] !== '0)}, 64'd0);
    rst = 1'b0;
    tick();

    // Three simultaneous reads: granted 0,1,2 one at a time.
    send(0, 1'b0, CLASSIC, 8'd10, 32'h200);
    send(1, 1'b0, CLASSIC, 8'd11, 32'h204);
    send(2, 1'b0, CLASSIC, 8'd12, 32'h208);
    tick();
    clr_reqs();
    for (int k = 0; k < 3; k++) begin
      wait_grant(8'(10 + k), "t2_order");
      tick();
      expect_rsp(k, 8'(10 + k), OKAY, 32'hA000_0000 + 32'(k));
      respond(8'(10 + k), OKAY, 32'hA000_0000 + 32'(k));
    end
    send(0, 1'b0, CLASSIC, 8'd20, 32'h300);
    send(1, 1'b0, CLASSIC, 8'd21, 32'h304);
    tick();
    clr_reqs();
    wait_grant(8'd20, "t2_rr_first");
    tick();
    expect_rsp(0, 8'd20, OKAY, 32'h0000_0020);
    respond(8'd20, OKAY, 32'h0000_0020);
    wait_grant(8'd21, "t2_rr_second");
    tick();
    expect_rsp(1, 8'd21, OKAY, 32'h0000_0021);
    respond(8'd21, OKAY, 32'h0000_0021);

    // Port 0 read, response three cycles into WAIT.
    send(0, 1'b0, CLASSIC, 8'd5, 32'h100);
    tick();
    clr_reqs();
    wait_grant(8'd5, "t1_grant");
    chk("t1_adr", {32'd0, br_req_o.adr}, 64'h100);
    repeat (3) tick();
    expect_rsp(0, 8'd5, OKAY, 32'h1234_5678);
    respond(8'd5, OKAY, 32'h1234_5678);

    // Posted write: no response, stall drops after ISSUE, next grant waits for wb_ack_i.
    send(1, 1'b1, CLASSIC, 8'd30, 32'h400);
    tick();
    clr_reqs();
    wait_grant(8'd30, "t3_wr_grant");
    chk("t3_stall_issue", {63'd0, stall_o[1]}, 64'd1);
    tick();
    send(2, 1'b0, CLASSIC, 8'd31, 32'h408);
    @(negedge clk);
    chk("t3_stall_wait", {63'd0, stall_o[1]}, 64'd0);
    tick();
    clr_reqs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_hold", {63'd0, br_req_o.cyc}, 64'd0);
      tick();
    end
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    wait_grant(8'd31, "t3_next_grant");
    tick();
    expect_rsp(2, 8'd31, OKAY, 32'h0000_0031);
    respond(8'd31, OKAY, 32'h0000_0031);
    send(1, 1'b1, ERC, 8'd32, 32'h40C);
    tick();
    clr_reqs();
    wait_grant(8'd32, "t3_erc_grant");
    tick();
    expect_rsp(1, 8'd32, OKAY, 32'h0);
    respond(8'd32, OKAY, 32'h0);

    // Read with no answer: to_o 17 cycles after ISSUE (timer 0..16), then DECERR.
    send(2, 1'b0, CLASSIC, 8'd40, 32'h500);
    tick();
    clr_reqs();
    wait_grant(8'd40, "t4_grant");
    expect_rsp(2, 8'd40, DECERR, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!to_o && n < 40);
    chk("t4_to_cycle", 64'(n), 64'd17);
    @(negedge clk);
    chk("t4_to_pulse", {63'd0, to_o}, 64'd0);
    tick();
    send(3, 1'b0, CLASSIC, 8'd41, 32'h504);
    tick();
    clr_reqs();
    wait_grant(8'd41, "t4_next_grant");
    tick();
    expect_rsp(3, 8'd41, OKAY, 32'h0000_0041);
    respond(8'd41, OKAY, 32'h0000_0041);

    // IRQ during a port 3 read, then a stale tid, then the real completion.
    send(3, 1'b0, CLASSIC, 8'd50, 32'h600);
    tick();
    clr_reqs();
    wait_grant(8'd50, "t5_grant");
    tick();
    expect_rsp(0, 8'd0, IRQ, 32'hFFFF_FFF0);
    respond(8'd0, IRQ, 32'hFFFF_FFF0);
    respond(8'd99, OKAY, 32'hDEAD_BEEF);
    expect_rsp(3, 8'd50, OKAY, 32'hCAFE_0050);
    respond(8'd50, OKAY, 32'hCAFE_0050);

    // IRQ coincides with a timeout on the IRQ port: IRQ first, DECERR a cycle later.
    send(0, 1'b0, CLASSIC, 8'd60, 32'h700);
    tick();
    clr_reqs();
    wait_grant(8'd60, "t5b_grant");
    repeat (17) tick();
    expect_rsp(0, 8'd0, IRQ, 32'hFFFF_FFF1);
    expect_rsp(0, 8'd60, DECERR, 32'h0);
    br_resp_i     = '0;
    br_resp_i.ack = 1'b1;
    br_resp_i.err = IRQ;
    br_resp_i.dat = 32'hFFFF_FFF1;
    @(negedge clk);
    chk("t5b_to", {63'd0, to_o}, 64'd1);
    tick();
    br_resp_i = '0;
    repeat (3) tick();

    // Reset during WAIT: late response dropped, then normal service.
    send(1, 1'b0, CLASSIC, 8'd70, 32'h800);
    tick();
    clr_reqs();
    wait_grant(8'd70, "t6_grant");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    respond(8'd70, OKAY, 32'h7070_7070);
    @(negedge clk);
    chk("t6_stall", {60'd0, stall_o}, 64'd0);
    chk("t6_brcyc", {63'd0, br_req_o.cyc}, 64'd0);
    chk("t6_to", {63'd0, to_o}, 64'd0);
    for (int p = 0; p < 4; p++) chk("t6_resp", {63'd0, (resp_o[p] !== '0)}, 64'd0);
    tick();
    send(0, 1'b0, CLASSIC, 8'd71, 32'h900);
    tick();
    clr_reqs();
    wait_grant(8'd71, "t6_after_rst");
    tick();
    expect_rsp(0, 8'd71, OKAY, 32'h0000_0071);
    respond(8'd71, OKAY, 32'h0000_0071);

    repeat (5) tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
